muldiv_iter: RTL and testbench

//  Parametrised iterative multiply/divide unit with architectural HI/LO registers. Serves the
//  MUL/MULU, MADD/MADDU, DIV/DIVU, MTHI/MTLO and MFHI/MFLO path of the execute stage.

---
 rtl/muldiv_iter_if.sv | 26 ++
 rtl/muldiv_iter.sv | 181 ++++++++++++++++++
 tb/tb_muldiv_iter.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_iter_if.sv
// Request/response bundle between the execute stage and the iterative multiply/divide unit.
// The master modport belongs to the issuing stage and the slave modport to muldiv_iter.
interface muldiv_iter_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  op_valid;
  logic [2:0]            op;
  logic                  op_unsigned;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic                  flush;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] hi;
  logic [DATA_WIDTH-1:0] lo;

  modport master (
    output op_valid, op, op_unsigned, a, b, flush,
    input  busy, done, hi, lo
  );

  modport slave (
    input  op_valid, op, op_unsigned, a, b, flush,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide unit with HI/LO: shift-add multiply retiring MUL_BITS per cycle,
// restoring radix-2 divide, and a final FIX cycle that applies signs and writes HI/LO.
module muldiv_iter #(
  parameter int DATA_WIDTH = 32,
  parameter int MUL_BITS   = 8,
  parameter int CNT_WIDTH  = 6
) (
  input  logic          clock,
  input  logic          reset,
  muldiv_iter_if.slave  bus
);
  localparam int W = DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] MUL_LAST = CNT_WIDTH'(DATA_WIDTH / MUL_BITS - 1);
  localparam logic [CNT_WIDTH-1:0] DIV_LAST = CNT_WIDTH'(DATA_WIDTH - 1);

  localparam logic [2:0] OP_MUL  = 3'd0;
  localparam logic [2:0] OP_MADD = 3'd1;
  localparam logic [2:0] OP_DIV  = 3'd2;
  localparam logic [2:0] OP_MTHI = 3'd3;
  localparam logic [2:0] OP_MTLO = 3'd4;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t               state, state_next;
  logic [CNT_WIDTH-1:0] cnt;
  logic [2*W-1:0]       mcand_sh;
  logic [W-1:0]         mplier;
  logic [2*W-1:0]       partial;
  logic [W-1:0]         quo;
  logic [W-1:0]         rem;
  logic [W-1:0]         divisor;
  logic [W-1:0]         a_raw;
  logic                 res_neg;
  logic                 rem_neg;
  logic                 is_madd;
  logic                 is_div;
  logic                 done;
  logic [W-1:0]         hi;
  logic [W-1:0]         lo;

  logic                 accept;
  logic [2*W-1:0]       pp;
  logic [W:0]           trial;
  logic [2*W-1:0]       product;

  function automatic logic [W-1:0] magnitude(input logic signed [W-1:0] v, input logic uns);
    logic [W-1:0] r;
    r = v;
    if (!uns && v[W-1]) r = ~r + 1'b1;
    return r;
  endfunction

  function automatic logic [W-1:0] sign_apply(input logic [W-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*W-1:0] sign_apply2(input logic [2*W-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  assign accept  = (state == IDLE) && bus.op_valid && !bus.flush;
  assign pp      = mcand_sh * {{(2*W-MUL_BITS){1'b0}}, mplier[MUL_BITS-1:0]};
  // Borrow out of the (W+1)-bit trial subtraction means the divisor did not fit.
  assign trial   = {rem, quo[W-1]} - {1'b0, divisor};
  assign product = sign_apply2(partial, res_neg);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (bus.flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (accept && (bus.op == OP_MUL || bus.op == OP_MADD)) state_next = MUL;
          else if (accept && bus.op == OP_DIV)                   state_next = DIV;
        end
        MUL:     if (cnt == MUL_LAST) state_next = FIX;
        DIV:     if (cnt == DIV_LAST) state_next = FIX;
        FIX:     state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      mcand_sh <= '0;
      mplier   <= '0;
      partial  <= '0;
      quo      <= '0;
      rem      <= '0;
      divisor  <= '0;
      a_raw    <= '0;
      res_neg  <= 1'b0;
      rem_neg  <= 1'b0;
      is_madd  <= 1'b0;
      is_div   <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      if (bus.flush) begin
        cnt <= '0;
      end else begin
        case (state)
          IDLE: if (accept) begin
            cnt <= '0;
            case (bus.op)
              OP_MTHI: hi <= bus.a;
              OP_MTLO: lo <= bus.a;
              OP_MUL, OP_MADD: begin
                mcand_sh <= {{W{1'b0}}, magnitude(bus.a, bus.op_unsigned)};
                mplier   <= magnitude(bus.b, bus.op_unsigned);
                partial  <= '0;
                res_neg  <= !bus.op_unsigned && (bus.a[W-1] ^ bus.b[W-1]);
                is_madd  <= (bus.op == OP_MADD);
                is_div   <= 1'b0;
              end
              OP_DIV: begin
                quo     <= magnitude(bus.a, bus.op_unsigned);
                divisor <= magnitude(bus.b, bus.op_unsigned);
                rem     <= '0;
                a_raw   <= bus.a;
                res_neg <= !bus.op_unsigned && (bus.a[W-1] ^ bus.b[W-1]);
                rem_neg <= !bus.op_unsigned && bus.a[W-1];
                is_div  <= 1'b1;
              end
              default: ;
            endcase
          end
          MUL: begin
            partial  <= partial + pp;
            mcand_sh <= mcand_sh << MUL_BITS;
            mplier   <= mplier >> MUL_BITS;
            cnt      <= cnt + 1'b1;
          end
          DIV: begin
            if (!trial[W]) begin
              rem <= trial[W-1:0];
              quo <= {quo[W-2:0], 1'b1};
            end else begin
              rem <= {rem[W-2:0], quo[W-1]};
              quo <= {quo[W-2:0], 1'b0};
            end
            cnt <= cnt + 1'b1;
          end
          FIX: begin
            done <= 1'b1;
            if (is_div) begin
              // Divide by zero leaves the raw dividend in HI and all ones in LO.
              if (divisor == '0) begin
                hi <= a_raw;
                lo <= '1;
              end else begin
                lo <= sign_apply(quo, res_neg);
                hi <= sign_apply(rem, rem_neg);
              end
            end else if (is_madd) begin
              {hi, lo} <= {hi, lo} + product;
            end else begin
              {hi, lo} <= product;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = done;
  assign bus.hi   = hi;
  assign bus.lo   = lo;
endmodule

// File: tb/tb_muldiv_iter.sv
// Directed bench for muldiv_iter: stimulus pushes expected HI/LO into a queue and a
// negedge monitor pops and compares on every done pulse.
module tb_muldiv_iter;
  logic clock = 1'b0;
  logic reset;

  muldiv_iter_if #(.DATA_WIDTH(32)) bus ();

  muldiv_iter #(.DATA_WIDTH(32), .MUL_BITS(8), .CNT_WIDTH(6)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          tag;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  localparam logic [2:0] OP_MUL  = 3'd0;
  localparam logic [2:0] OP_MADD = 3'd1;
  localparam logic [2:0] OP_DIV  = 3'd2;
  localparam logic [2:0] OP_MTHI = 3'd3;
  localparam logic [2:0] OP_MTLO = 3'd4;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic expect_res(input logic [31:0] hi, input logic [31:0] lo, input int tag);
    exp_t e;
    e.hi = hi;
    e.lo = lo;
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic [2:0] op, input logic uns, input logic [31:0] a,
                       input logic [31:0] b);
    @(negedge clock);
    bus.op_valid    = 1'b1;
    bus.op          = op;
    bus.op_unsigned = uns;
    bus.a           = a;
    bus.b           = b;
    @(posedge clock);
    #1 bus.op_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int lat);
    int  n;
    bit  seen;
    n = 0;
    seen = 1'b0;
    while (n < 100 && !seen) begin
      @(posedge clock);
      #1;
      n++;
      if (bus.done) seen = 1'b1;
    end
    chk(name, 64'(n), 64'(lat));
  endtask

  // Scoreboard monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (reset === 1'b0 && bus.done === 1'b1) begin
      chk("busy_done_exclusive", 64'(bus.busy), 64'd0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got hi=%0h lo=%0h expected no done", bus.hi, bus.lo);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk($sformatf("result_%0d", e.tag), {bus.hi, bus.lo}, {e.hi, e.lo});
      end
    end
  end

  initial begin
    reset           = 1'b1;
    bus.op_valid    = 1'b0;
    bus.op          = 3'd0;
    bus.op_unsigned = 1'b0;
    bus.a           = '0;
    bus.b           = '0;
    bus.flush       = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_done", 64'(bus.done), 64'd0);
    chk("reset_hilo", {bus.hi, bus.lo}, 64'd0);
    @(negedge clock);
    reset = 1'b0;

    // Multiply and multiply-accumulate
    expect_res(32'hFFFFFFFE, 32'h00000001, 1);
    issue(OP_MUL, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done("lat_mulu", 5);
    expect_res(32'hFFFFFFFF, 32'hFFFFFFEB, 2);
    issue(OP_MUL, 1'b0, -32'sd3, 32'd7);
    wait_done("lat_mul", 5);
    expect_res(32'hFFFFFFFF, 32'hFFFFFFF1, 3);
    issue(OP_MADD, 1'b0, 32'd2, 32'd3);
    wait_done("lat_madd", 5);
    expect_res(32'h00000000, 32'h80000000, 4);
    issue(OP_MUL, 1'b0, 32'h80000000, 32'hFFFFFFFF);
    wait_done("lat_mul_min", 5);

    // Divide, including zero divisor and signed overflow
    expect_res(32'hFFFFFFFF, 32'hFFFFFFFD, 5);
    issue(OP_DIV, 1'b0, -32'sd7, 32'd2);
    wait_done("lat_div", 33);
    expect_res(32'd2, 32'd14, 6);
    issue(OP_DIV, 1'b1, 32'd100, 32'd7);
    wait_done("lat_divu", 33);
    expect_res(32'd1, 32'hFFFFFFFD, 7);
    issue(OP_DIV, 1'b0, 32'd7, -32'sd2);
    wait_done("lat_div_negb", 33);
    expect_res(32'd5, 32'hFFFFFFFF, 8);
    issue(OP_DIV, 1'b0, 32'd5, 32'd0);
    wait_done("lat_div0", 33);
    expect_res(32'hFFFFFFF0, 32'hFFFFFFFF, 9);
    issue(OP_DIV, 1'b1, 32'hFFFFFFF0, 32'd0);
    wait_done("lat_divu0", 33);
    expect_res(32'd0, 32'h80000000, 10);
    issue(OP_DIV, 1'b0, 32'h80000000, 32'hFFFFFFFF);
    wait_done("lat_div_ovf", 33);

    issue(3'd6, 1'b0, 32'h1111, 32'h2222);
    chk("noop_busy", 64'(bus.busy), 64'd0);
    chk("noop_hilo", {bus.hi, bus.lo}, {32'd0, 32'h80000000});

    // Back-to-back MTHI/MTLO never raise busy
    @(negedge clock);
    bus.op_valid = 1'b1;
    bus.op       = OP_MTHI;
    bus.a        = 32'h1234;
    @(posedge clock);
    #1;
    chk("mthi_busy", 64'(bus.busy), 64'd0);
    bus.op = OP_MTLO;
    bus.a  = 32'h5678;
    @(posedge clock);
    #1;
    bus.op_valid = 1'b0;
    chk("mtlo_busy", 64'(bus.busy), 64'd0);
    chk("mt_hilo", {bus.hi, bus.lo}, {32'h1234, 32'h5678});

    // Request presented while a divide is in flight is dropped
    expect_res(32'd2, 32'd14, 11);
    issue(OP_DIV, 1'b1, 32'd100, 32'd7);
    repeat (3) @(posedge clock);
    issue(OP_MTHI, 1'b0, 32'hDEAD, 32'd0);
    wait_done("lat_div_ignore", 29);

    // Flush at iteration 10 of a divide
    issue(OP_DIV, 1'b0, 32'd1000, 32'd3);
    repeat (9) @(posedge clock);
    @(negedge clock);
    bus.flush = 1'b1;
    @(posedge clock);
    #1;
    bus.flush = 1'b0;
    chk("flush_busy", 64'(bus.busy), 64'd0);
    repeat (40) @(posedge clock);
    #1;
    chk("flush_hilo", {bus.hi, bus.lo}, {32'd2, 32'd14});

    @(negedge clock);
    bus.op_valid = 1'b1;
    bus.op       = OP_MTHI;
    bus.a        = 32'hBAD;
    bus.flush    = 1'b1;
    @(posedge clock);
    #1;
    bus.op_valid = 1'b0;
    bus.flush    = 1'b0;
    chk("mthi_flush_hi", 64'(bus.hi), 64'd2);

    @(negedge clock);
    bus.op_valid = 1'b1;
    bus.op       = OP_MUL;
    bus.a        = 32'd3;
    bus.b        = 32'd5;
    bus.flush    = 1'b1;
    @(posedge clock);
    #1;
    bus.op_valid = 1'b0;
    bus.flush    = 1'b0;
    chk("mul_flush_busy", 64'(bus.busy), 64'd0);

    // Asynchronous reset in the middle of a multiply
    issue(OP_MUL, 1'b1, 32'd3, 32'd5);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("rst_mid_hilo", {bus.hi, bus.lo}, 64'd0);
    chk("rst_mid_busy", 64'(bus.busy), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    chk("rst_after_busy", 64'(bus.busy), 64'd0);
    chk("rst_after_hilo", {bus.hi, bus.lo}, 64'd0);

    repeat (3) @(posedge clock);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
